// File: rtl/if_prefetch_buffer_pkg.sv
//============================================================================
// Module  : if_prefetch_buffer_pkg
// Brief   : Shared widths, depth and FIFO entry type for the IF prefetch buffer.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

package if_prefetch_buffer_pkg;

    localparam int WORD_WIDTH     = 32;
    localparam int PREFETCH_DEPTH = 4;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] addr;
        logic [WORD_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/if_prefetch_buffer_if.sv
//============================================================================
// Module  : if_prefetch_buffer_if
// Brief   : Instruction-memory bus and IF-stage handshake of the prefetch buffer.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

interface if_prefetch_buffer_if;
    import if_prefetch_buffer_pkg::*;

    logic                  instr_req_o;
    logic [WORD_WIDTH-1:0] instr_addr_o;
    logic                  instr_gnt_i;
    logic                  instr_rvalid_i;
    logic [WORD_WIDTH-1:0] instr_rdata_i;

    logic                  fetch_valid_o;
    logic                  fetch_ready_i;
    logic [WORD_WIDTH-1:0] fetch_instr_o;
    logic [WORD_WIDTH-1:0] fetch_addr_o;

    // master: the prefetch buffer; slave: memory plus IF stage
    modport master (
        output instr_req_o, instr_addr_o, fetch_valid_o, fetch_instr_o, fetch_addr_o,
        input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, fetch_ready_i
    );

    modport slave (
        input  instr_req_o, instr_addr_o, fetch_valid_o, fetch_instr_o, fetch_addr_o,
        output instr_gnt_i, instr_rvalid_i, instr_rdata_i, fetch_ready_i
    );

endinterface

`default_nettype wire

// File: rtl/if_prefetch_buffer_fifo.sv
//============================================================================
// Module  : if_prefetch_buffer_fifo
// Brief   : Synchronous FIFO of fetch entries; flush overrides push and pop.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module if_prefetch_buffer_fifo
    import if_prefetch_buffer_pkg::*;
#(
    parameter int DEPTH = PREFETCH_DEPTH
) (
    input  wire logic                         clk,
    input  wire logic                         rst_n,
    input  wire logic                         i_push,
    input  wire fetch_entry_t                 i_push_data,
    input  wire logic                         i_pop,
    input  wire logic                         i_flush,
    output logic                              o_valid,
    output fetch_entry_t                      o_head,
    output logic [$clog2(DEPTH + 1)-1:0]      o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t         r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 w_do_pop;

    assign w_do_pop = i_pop && (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(i_push) - c_CNT_W'(w_do_pop);
        end
    end

    assign o_valid = (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/if_prefetch_buffer.sv
//============================================================================
// Module  : if_prefetch_buffer
// Brief   : Sequential instruction prefetcher with redirect flush and discard.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module if_prefetch_buffer
    import if_prefetch_buffer_pkg::*;
#(
    parameter int DEPTH = PREFETCH_DEPTH
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  fetch_en_i,
    input  wire logic [WORD_WIDTH-1:0] pc_start_addr_i,
    input  wire logic                  redirect_i,
    input  wire logic [WORD_WIDTH-1:0] redirect_addr_i,
    if_prefetch_buffer_if.master       bus
);

    localparam int                    c_CNT_W      = $clog2(DEPTH + 1);
    localparam logic [WORD_WIDTH-1:0] c_WORD_BYTES = WORD_WIDTH'(4);
    localparam logic [0:0]            c_S_IDLE     = 1'b0;
    localparam logic [0:0]            c_S_REQ      = 1'b1;

    logic [0:0]             r_state;
    logic                   r_started;
    logic                   r_req_stale;
    logic [WORD_WIDTH-1:0]  r_req_addr;
    logic [WORD_WIDTH-1:0]  r_next_addr;
    logic [WORD_WIDTH-1:0]  r_rsp_addr;
    logic [c_CNT_W-1:0]     r_outstanding;
    logic [c_CNT_W-1:0]     r_discard;

    logic                   w_req_pending;
    logic                   w_grant;
    logic                   w_grant_fresh;
    logic                   w_rsp;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_credit;
    logic                   w_issue;
    logic [c_CNT_W:0]       w_inflight;
    logic [c_CNT_W-1:0]     w_count;
    logic [c_CNT_W-1:0]     w_outstanding_nxt;
    logic [c_CNT_W-1:0]     w_discard_nxt;
    logic [WORD_WIDTH-1:0]  w_next_addr_nxt;
    logic [WORD_WIDTH-1:0]  w_rsp_addr_nxt;
    logic                   w_fifo_valid;
    fetch_entry_t           w_head;
    fetch_entry_t           w_push_data;

    assign w_req_pending = (r_state == c_S_REQ);
    assign w_grant       = w_req_pending && bus.instr_gnt_i;
    assign w_grant_fresh = w_grant && !r_req_stale;
    // rvalid with nothing outstanding is ignored entirely
    assign w_rsp         = bus.instr_rvalid_i && (r_outstanding != '0);
    assign w_push        = w_rsp && (r_discard == '0) && !redirect_i;
    assign w_pop         = w_fifo_valid && bus.fetch_ready_i;
    assign w_inflight    = (c_CNT_W + 1)'(w_count) + (c_CNT_W + 1)'(r_outstanding)
                         + (c_CNT_W + 1)'(w_req_pending);
    assign w_credit      = (w_inflight < (c_CNT_W + 1)'(DEPTH));
    assign w_issue       = fetch_en_i && w_credit;
    assign w_push_data   = '{addr: r_rsp_addr, instr: bus.instr_rdata_i};

    assign w_outstanding_nxt = r_outstanding + c_CNT_W'(w_grant) - c_CNT_W'(w_rsp);

    always_comb begin
        w_next_addr_nxt = r_next_addr;
        w_rsp_addr_nxt  = r_rsp_addr;
        w_discard_nxt   = r_discard;
        if (redirect_i) begin
            w_next_addr_nxt = redirect_addr_i;
            w_rsp_addr_nxt  = redirect_addr_i;
            // Every request still owed a response belongs to the old path
            w_discard_nxt   = w_outstanding_nxt;
        end else begin
            if (!r_started) begin
                w_next_addr_nxt = pc_start_addr_i;
                w_rsp_addr_nxt  = pc_start_addr_i;
            end else if (w_grant_fresh) begin
                w_next_addr_nxt = r_next_addr + c_WORD_BYTES;
            end
            if (w_push) begin
                w_rsp_addr_nxt = r_rsp_addr + c_WORD_BYTES;
            end
            w_discard_nxt = r_discard
                          - c_CNT_W'(w_rsp && (r_discard != '0))
                          + c_CNT_W'(w_grant && r_req_stale);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_S_IDLE;
            r_started     <= 1'b0;
            r_req_stale   <= 1'b0;
            r_req_addr    <= '0;
            r_next_addr   <= '0;
            r_rsp_addr    <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            if (fetch_en_i) begin
                r_started <= 1'b1;
            end
            r_next_addr   <= w_next_addr_nxt;
            r_rsp_addr    <= w_rsp_addr_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_discard     <= w_discard_nxt;
            case (r_state)
                c_S_IDLE: begin
                    if (w_issue) begin
                        r_state     <= c_S_REQ;
                        r_req_addr  <= w_next_addr_nxt;
                        r_req_stale <= 1'b0;
                    end
                end
                c_S_REQ: begin
                    if (bus.instr_gnt_i) begin
                        r_req_stale <= 1'b0;
                        if (w_issue) begin
                            r_req_addr <= w_next_addr_nxt;
                        end else begin
                            r_state <= c_S_IDLE;
                        end
                    end else if (redirect_i) begin
                        // Held request keeps its old address; its data is dropped later
                        r_req_stale <= 1'b1;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    if_prefetch_buffer_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (redirect_i),
        .o_valid     (w_fifo_valid),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign bus.instr_req_o   = w_req_pending;
    assign bus.instr_addr_o  = r_req_addr;
    assign bus.fetch_valid_o = w_fifo_valid;
    assign bus.fetch_instr_o = w_head.instr;
    assign bus.fetch_addr_o  = w_head.addr;

    a_no_stray_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
        bus.instr_rvalid_i |-> (r_outstanding != '0));

endmodule

`default_nettype wire

// File: tb/tb_if_prefetch_buffer.sv
//============================================================================
// Module  : tb_if_prefetch_buffer
// Brief   : Directed self-checking bench for the IF prefetch buffer.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_if_prefetch_buffer;
    import if_prefetch_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] pc_start = '0;
    logic [31:0] redirect_addr = '0;

    logic        gnt_en;
    logic        rsp_en;
    int          n_checks = 0;
    int          n_fail = 0;

    logic [31:0]  q_granted [$];
    logic [31:0]  q_rsp [$];
    fetch_entry_t q_deliv [$];

    if_prefetch_buffer_if bus ();

    if_prefetch_buffer #(
        .DEPTH (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_en_i      (fetch_en),
        .pc_start_addr_i (pc_start),
        .redirect_i      (redirect),
        .redirect_addr_i (redirect_addr),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Records what the DUT sees at the coming edge, then drives memory for the next cycle
    task automatic tick();
        if (rst_n) begin
            if (bus.fetch_valid_o && bus.fetch_ready_i)
                q_deliv.push_back('{addr: bus.fetch_addr_o, instr: bus.fetch_instr_o});
            if (bus.instr_req_o && bus.instr_gnt_i) begin
                q_granted.push_back(bus.instr_addr_o);
                q_rsp.push_back(bus.instr_addr_o);
            end
        end
        @(posedge clk);
        #1;
        if (rsp_en && q_rsp.size() > 0) begin
            bus.instr_rvalid_i = 1'b1;
            bus.instr_rdata_i  = ~q_rsp.pop_front();
        end else begin
            bus.instr_rvalid_i = 1'b0;
            bus.instr_rdata_i  = '0;
        end
        bus.instr_gnt_i = gnt_en && bus.instr_req_o;
    endtask

    task automatic do_reset(input logic [31:0] pc);
        rst_n              = 1'b0;
        fetch_en           = 1'b0;
        redirect           = 1'b0;
        redirect_addr      = '0;
        pc_start           = pc;
        gnt_en             = 1'b1;
        rsp_en             = 1'b1;
        bus.fetch_ready_i  = 1'b1;
        bus.instr_gnt_i    = 1'b0;
        bus.instr_rvalid_i = 1'b0;
        bus.instr_rdata_i  = '0;
        q_rsp.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        q_deliv.delete();
        q_granted.delete();
    endtask

    initial begin
        // 1: streaming fetch from 0x80
        do_reset(32'h80);
        chk("rst_req",   bus.instr_req_o,   0);
        chk("rst_addr",  bus.instr_addr_o,  0);
        chk("rst_valid", bus.fetch_valid_o, 0);
        chk("rst_instr", bus.fetch_instr_o, 0);
        chk("rst_faddr", bus.fetch_addr_o,  0);
        fetch_en = 1'b1;
        tick();
        chk("t1_valid_c1", bus.fetch_valid_o, 0);
        chk("t1_req_c1",   bus.instr_req_o,   1);
        chk("t1_addr_c1",  bus.instr_addr_o,  32'h80);
        tick();
        chk("t1_valid_c2", bus.fetch_valid_o, 0);
        chk("t1_addr_c2",  bus.instr_addr_o,  32'h84);
        tick();
        chk("t1_valid_c3", bus.fetch_valid_o, 1);
        chk("t1_faddr_c3", bus.fetch_addr_o,  32'h80);
        chk("t1_instr_c3", bus.fetch_instr_o, ~32'h80);
        repeat (6) tick();
        chk("t1_ndeliv", 32'(q_deliv.size() >= 4), 1);
        for (int i = 0; i < 4; i++) begin
            chk("t1_deliv_addr",  q_deliv[i].addr,  32'h80 + 32'(4 * i));
            chk("t1_deliv_instr", q_deliv[i].instr, ~(32'h80 + 32'(4 * i)));
        end

        // 2: consumer stalled, credit caps issue at DEPTH
        do_reset(32'h80);
        bus.fetch_ready_i = 1'b0;
        fetch_en = 1'b1;
        repeat (12) tick();
        chk("t2_ngrant",  32'(q_granted.size()), 4);
        chk("t2_grant0",  q_granted[0], 32'h80);
        chk("t2_grant3",  q_granted[3], 32'h8C);
        chk("t2_req_off", bus.instr_req_o,   0);
        chk("t2_valid",   bus.fetch_valid_o, 1);
        chk("t2_head",    bus.fetch_addr_o,  32'h80);
        bus.fetch_ready_i = 1'b1;
        repeat (6) tick();
        chk("t2_resume",  32'(q_granted.size() > 4), 1);
        chk("t2_grant4",  q_granted[4], 32'h90);
        chk("t2_deliv3",  q_deliv[3].addr, 32'h8C);

        // 3: grant withheld for five cycles
        do_reset(32'h80);
        fetch_en = 1'b1;
        tick();
        chk("t3_addr0", bus.instr_addr_o, 32'h80);
        gnt_en = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_req",  bus.instr_req_o,  1);
            chk("t3_hold_addr", bus.instr_addr_o, 32'h84);
            if (k == 4) gnt_en = 1'b1;
            tick();
        end
        chk("t3_gnt_addr",  bus.instr_addr_o, 32'h84);
        chk("t3_ngrant_a",  32'(q_granted.size()), 1);
        tick();
        chk("t3_ngrant_b",  32'(q_granted.size()), 2);
        chk("t3_grant1",    q_granted[1], 32'h84);
        chk("t3_next_addr", bus.instr_addr_o, 32'h88);

        // 4: redirect with two outstanding and one buffered
        do_reset(32'h80);
        bus.fetch_ready_i = 1'b0;
        fetch_en = 1'b1;
        tick();
        tick();
        rsp_en = 1'b0;
        tick();
        fetch_en = 1'b0;
        tick();
        chk("t4_pre_req",   bus.instr_req_o,   0);
        chk("t4_pre_valid", bus.fetch_valid_o, 1);
        chk("t4_pre_head",  bus.fetch_addr_o,  32'h80);
        chk("t4_ngrant",    32'(q_granted.size()), 3);
        redirect = 1'b1;
        redirect_addr = 32'h200;
        fetch_en = 1'b1;
        tick();
        redirect = 1'b0;
        rsp_en = 1'b1;
        bus.fetch_ready_i = 1'b1;
        chk("t4_flush_valid", bus.fetch_valid_o, 0);
        chk("t4_new_req",     bus.instr_req_o,   1);
        chk("t4_new_addr",    bus.instr_addr_o,  32'h200);
        tick();
        chk("t4_drop1_valid", bus.fetch_valid_o, 0);
        tick();
        chk("t4_drop2_valid", bus.fetch_valid_o, 0);
        tick();
        chk("t4_nobypass",    bus.fetch_valid_o, 0);
        tick();
        chk("t4_valid",       bus.fetch_valid_o, 1);
        chk("t4_faddr",       bus.fetch_addr_o,  32'h200);
        chk("t4_finstr",      bus.fetch_instr_o, ~32'h200);

        // 5: redirect while a request is held ungranted
        do_reset(32'h90);
        gnt_en = 1'b0;
        fetch_en = 1'b1;
        tick();
        chk("t5_req",  bus.instr_req_o,  1);
        chk("t5_addr", bus.instr_addr_o, 32'h90);
        redirect = 1'b1;
        redirect_addr = 32'h200;
        tick();
        redirect = 1'b0;
        chk("t5_held_a", bus.instr_addr_o, 32'h90);
        chk("t5_valid",  bus.fetch_valid_o, 0);
        tick();
        chk("t5_held_b", bus.instr_addr_o, 32'h90);
        gnt_en = 1'b1;
        tick();
        chk("t5_held_c", bus.instr_addr_o, 32'h90);
        tick();
        chk("t5_new_req",  bus.instr_req_o,  1);
        chk("t5_new_addr", bus.instr_addr_o, 32'h200);
        repeat (4) tick();
        chk("t5_deliv_addr",  q_deliv[0].addr,  32'h200);
        chk("t5_deliv_instr", q_deliv[0].instr, ~32'h200);

        // 6: asynchronous reset mid-burst, then restart
        do_reset(32'h80);
        rsp_en = 1'b0;
        fetch_en = 1'b1;
        repeat (4) tick();
        chk("t6_ngrant", 32'(q_granted.size()), 3);
        chk("t6_req",    bus.instr_req_o,  1);
        chk("t6_addr",   bus.instr_addr_o, 32'h8C);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_arst_req",   bus.instr_req_o,   0);
        chk("t6_arst_addr",  bus.instr_addr_o,  0);
        chk("t6_arst_valid", bus.fetch_valid_o, 0);
        rsp_en = 1'b1;
        fetch_en = 1'b0;
        pc_start = 32'h400;
        repeat (4) tick();
        chk("t6_stale_drained", 32'(q_rsp.size()), 0);
        rst_n = 1'b1;
        q_granted.delete();
        q_deliv.delete();
        tick();
        chk("t6_post_req",   bus.instr_req_o,   0);
        chk("t6_post_valid", bus.fetch_valid_o, 0);
        fetch_en = 1'b1;
        repeat (8) tick();
        chk("t6_restart0",       q_deliv[0].addr,  32'h400);
        chk("t6_restart0_instr", q_deliv[0].instr, ~32'h400);
        chk("t6_restart1",       q_deliv[1].addr,  32'h404);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
